// File: rtl/boot_loader_if.sv
// Byte stream from the serial receiver and write port into instruction memory.
interface boot_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              rcv_full;
  logic [7:0]        rcv_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;

  // Loader side: consumes bytes, drives the memory write port.
  modport master (
    input  rcv_full,
    input  rcv_data,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  // Environment side: supplies bytes, observes memory writes.
  modport slave (
    output rcv_full,
    output rcv_data,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/boot_loader.sv
// Serial boot loader: parses an A5-framed image of 16-bit words, writes them
// from address 0 into instruction memory and releases the CPU only after the
// frame checksum matches.
module boot_loader #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 2000000
) (
  input  logic          clk,
  input  logic          reset,
  boot_loader_if.master bus,
  output logic          cpu_reset,
  output logic          done,
  output logic          error
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [16:0] DEPTH = 17'(1 << ADDR_W);
  localparam logic [7:0]  SYNC  = 8'hA5;

  typedef enum logic [2:0] {
    IDLE, CNT_L, CNT_H, DAT_L, DAT_H, CHK, DONE, ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [16:0]       cnt_q, cnt_d;
  logic [16:0]       idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        low_q, low_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [15:0]       wdata_d;
  logic              done_d, error_d, cpu_reset_d;
  logic [16:0]       cnt_full;
  logic              in_frame;

  assign cnt_full = {1'b0, bus.rcv_data, cnt_q[7:0]};
  assign in_frame = (state_q == CNT_L) || (state_q == CNT_H) || (state_q == DAT_L) ||
                    (state_q == DAT_H) || (state_q == CHK);

  // Next-state, datapath and output decode; a strobe overrides a timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    low_d       = low_q;
    tmo_d       = tmo_q;
    we_d        = 1'b0;
    addr_d      = bus.mem_addr;
    wdata_d     = bus.mem_wdata;
    done_d      = done;
    error_d     = error;
    cpu_reset_d = cpu_reset;

    if (in_frame && !bus.rcv_full) begin
      if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
        state_d = IDLE;
        tmo_d   = '0;
        sum_d   = '0;
        idx_d   = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    if (bus.rcv_full) begin
      tmo_d = '0;
      unique case (state_q)
        IDLE: begin
          if (bus.rcv_data == SYNC) begin
            state_d = CNT_L;
            sum_d   = '0;
            idx_d   = '0;
          end
        end
        CNT_L: begin
          cnt_d   = {9'd0, bus.rcv_data};
          state_d = CNT_H;
        end
        CNT_H: begin
          cnt_d = cnt_full;
          if (cnt_full > DEPTH) begin
            state_d     = ERROR;
            error_d     = 1'b1;
            cpu_reset_d = 1'b1;
          end else if (cnt_full == 17'd0) begin
            state_d = CHK;
          end else begin
            state_d = DAT_L;
          end
        end
        DAT_L: begin
          low_d   = bus.rcv_data;
          sum_d   = sum_q + bus.rcv_data;
          state_d = DAT_H;
        end
        DAT_H: begin
          sum_d   = sum_q + bus.rcv_data;
          we_d    = 1'b1;
          addr_d  = ADDR_W'(idx_q);
          wdata_d = {bus.rcv_data, low_q};
          idx_d   = idx_q + 17'd1;
          state_d = (idx_q + 17'd1 < cnt_q) ? DAT_L : CHK;
        end
        CHK: begin
          if (bus.rcv_data == sum_q) begin
            state_d     = DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d     = ERROR;
            error_d     = 1'b1;
            cpu_reset_d = 1'b1;
          end
        end
        DONE:    state_d = DONE;
        ERROR:   state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      sum_q         <= '0;
      low_q         <= '0;
      tmo_q         <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
      cpu_reset     <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      sum_q         <= sum_d;
      low_q         <= low_d;
      tmo_q         <= tmo_d;
      bus.mem_we    <= we_d;
      bus.mem_addr  <= addr_d;
      bus.mem_wdata <= wdata_d;
      done          <= done_d;
      error         <= error_d;
      cpu_reset     <= cpu_reset_d;
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: expected memory writes are queued when bytes are
// sent and popped by a write monitor; status flags are checked per scenario.
module tb_boot_loader;

  localparam int unsigned TMO = 40;

  logic clk;
  logic reset;
  logic cpu_reset_a, done_a, error_a;
  logic cpu_reset_b, done_b, error_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t q_a[$];
  wr_t q_b[$];

  boot_loader_if #(.ADDR_W(10)) bus_a ();
  boot_loader_if #(.ADDR_W(4))  bus_b ();

  boot_loader #(.ADDR_W(10), .TIMEOUT(TMO)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.master),
    .cpu_reset(cpu_reset_a), .done(done_a), .error(error_a)
  );

  boot_loader #(.ADDR_W(4), .TIMEOUT(TMO)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.master),
    .cpu_reset(cpu_reset_b), .done(done_b), .error(error_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitors: every mem_we cycle must match the next queued write.
  always @(negedge clk) begin
    if (bus_a.mem_we === 1'b1) begin
      if (q_a.size() == 0) chk("a_unexpected_we", 32'd1, 32'd0);
      else begin
        wr_t e;
        e = q_a.pop_front();
        chk("a_addr", 32'(bus_a.mem_addr), 32'(e.addr));
        chk("a_data", 32'(bus_a.mem_wdata), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (bus_b.mem_we === 1'b1) begin
      if (q_b.size() == 0) chk("b_unexpected_we", 32'd1, 32'd0);
      else begin
        wr_t e;
        e = q_b.pop_front();
        chk("b_addr", 32'(bus_b.mem_addr), 32'(e.addr));
        chk("b_data", 32'(bus_b.mem_wdata), 32'(e.data));
      end
    end
  end

  task automatic send(input int sel, input logic [7:0] b);
    @(negedge clk);
    if (sel == 0) begin bus_a.rcv_full = 1'b1; bus_a.rcv_data = b; end
    else          begin bus_b.rcv_full = 1'b1; bus_b.rcv_data = b; end
    @(negedge clk);
    bus_a.rcv_full = 1'b0;
    bus_b.rcv_full = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic status_a(input string pfx, input logic d, input logic e, input logic c);
    chk({pfx, "_done"}, 32'(done_a), 32'(d));
    chk({pfx, "_error"}, 32'(error_a), 32'(e));
    chk({pfx, "_cpu_reset"}, 32'(cpu_reset_a), 32'(c));
  endtask

  // Reference frame: A5 02 00 34 12 78 56 CHK; words 0x1234, 0x5678.
  task automatic good_frame(input logic [7:0] chk_byte, input bit expect_ok, input string pfx);
    logic [7:0] hdr [3];
    logic [7:0] dat [4];
    hdr = '{8'hA5, 8'h02, 8'h00};
    dat = '{8'h34, 8'h12, 8'h78, 8'h56};
    q_a.push_back('{16'd0, 16'h1234});
    q_a.push_back('{16'd1, 16'h5678});
    foreach (hdr[i]) send(0, hdr[i]);
    foreach (dat[i]) send(0, dat[i]);
    chk({pfx, "_done_before_chk"}, 32'(done_a), 32'd0);
    send(0, chk_byte);
    if (expect_ok) status_a(pfx, 1'b1, 1'b0, 1'b0);
    else           status_a(pfx, 1'b0, 1'b1, 1'b1);
    chk({pfx, "_q_empty"}, 32'(q_a.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus_a.rcv_full = 1'b0; bus_a.rcv_data = 8'h00;
    bus_b.rcv_full = 1'b0; bus_b.rcv_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset values
    chk("rst_we", 32'(bus_a.mem_we), 32'd0);
    chk("rst_addr", 32'(bus_a.mem_addr), 32'd0);
    chk("rst_wdata", 32'(bus_a.mem_wdata), 32'd0);
    status_a("rst", 1'b0, 1'b0, 1'b1);

    // Good frame, then a trailing sync byte that must be ignored
    good_frame(8'h14, 1'b1, "good");
    send(0, 8'hA5);
    send(0, 8'h00);
    status_a("good_sticky", 1'b1, 1'b0, 1'b0);

    // Bad checksum: writes still happen, frame rejected
    do_reset();
    chk("rst2_addr", 32'(bus_a.mem_addr), 32'd0);
    status_a("rst2", 1'b0, 1'b0, 1'b1);
    good_frame(8'h15, 1'b0, "badchk");

    // Leading junk ignored
    do_reset();
    send(0, 8'h00); send(0, 8'hFF); send(0, 8'h5A);
    status_a("junk", 1'b0, 1'b0, 1'b1);
    good_frame(8'h14, 1'b1, "junk_good");

    // Empty frame: checksum of nothing is 0
    do_reset();
    send(0, 8'hA5); send(0, 8'h00); send(0, 8'h00);
    chk("empty_done_pre", 32'(done_a), 32'd0);
    send(0, 8'h00);
    status_a("empty_ok", 1'b1, 1'b0, 1'b0);
    do_reset();
    send(0, 8'hA5); send(0, 8'h00); send(0, 8'h00); send(0, 8'h01);
    status_a("empty_bad", 1'b0, 1'b1, 1'b1);

    // Timeout mid-frame returns to IDLE without flagging anything
    do_reset();
    send(0, 8'hA5); send(0, 8'h01); send(0, 8'h00); send(0, 8'h34);
    repeat (TMO + 5) @(negedge clk);
    status_a("tmo", 1'b0, 1'b0, 1'b1);
    good_frame(8'h14, 1'b1, "tmo_good");

    // A gap well under the timeout does not abort the frame
    do_reset();
    q_a.push_back('{16'd0, 16'hBEEF});
    send(0, 8'hA5); send(0, 8'h01); send(0, 8'h00); send(0, 8'hEF);
    repeat (TMO / 2) @(negedge clk);
    send(0, 8'hBE);
    send(0, 8'hAD);  // 0xEF + 0xBE = 0x1AD
    status_a("gap", 1'b1, 1'b0, 1'b0);
    chk("gap_q_empty", 32'(q_a.size()), 32'd0);

    // Reset after DAT_L: no write, CPU held, next frame loads from 0
    do_reset();
    send(0, 8'hA5); send(0, 8'h01); send(0, 8'h00); send(0, 8'h34);
    do_reset();
    repeat (2) @(negedge clk);
    status_a("midrst", 1'b0, 1'b0, 1'b1);
    good_frame(8'h14, 1'b1, "midrst_good");

    // Small memory: count = DEPTH + 1 rejected at CNT_H, no writes
    do_reset();
    send(1, 8'hA5); send(1, 8'h11);
    chk("big_error_pre", 32'(error_b), 32'd0);
    send(1, 8'h00);
    chk("big_error", 32'(error_b), 32'd1);
    chk("big_done", 32'(done_b), 32'd0);
    chk("big_cpu_reset", 32'(cpu_reset_b), 32'd1);
    repeat (4) @(negedge clk);

    // Small memory: count = DEPTH fills every address
    do_reset();
    begin
      logic [7:0] s;
      logic [15:0] w;
      s = 8'h00;
      send(1, 8'hA5); send(1, 8'h10); send(1, 8'h00);
      for (int i = 0; i < 16; i++) begin
        w = 16'(i * 16'h1313 + 16'h0A0B);
        q_b.push_back('{16'(i), w});
        send(1, w[7:0]);
        send(1, w[15:8]);
        s = s + w[7:0] + w[15:8];
      end
      send(1, s);
      chk("full_done", 32'(done_b), 32'd1);
      chk("full_error", 32'(error_b), 32'd0);
      chk("full_cpu_reset", 32'(cpu_reset_b), 32'd0);
      chk("full_q_empty", 32'(q_b.size()), 32'd0);
    end

    repeat (4) @(negedge clk);
    chk("final_qa_empty", 32'(q_a.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
